// File: rtl/packed_fifo_axis_framer.sv
// ----------------------------------------------------------------------------
// packed_fifo_axis_framer
//
// Purpose: frames the packed FIFO write stream coming out of the timestamping
// channel packer into AXI-Stream packets. Every packet starts on a sync
// (timestamp) word and is packet_words long (0 = unlimited). Accepted words
// pass through a one-entry staging register, then an internal FIFO, and then
// a first-word-fall-through AXI-Stream master. When the FIFO cannot take a
// word, the word is dropped and the open packet is closed early. Framing then
// resumes on the next sync word, so every downstream packet begins with a
// timestamp.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   enable               framing enable; low closes the open packet and
//                        ignores input
//   packet_words         words per packet including the timestamp; 0 = no
//                        limit
//   fifo_wr_en/_sync/_data   upstream write strobe, packet-start flag, word
//   fifo_wr_overflow     registered one-cycle pulse per dropped input word
//   m_axis_*             AXI-Stream master (user = first word, last = final
//                        word)
//   drop_count           saturating count of dropped input words
// ----------------------------------------------------------------------------
module packed_fifo_axis_framer #(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [15:0]           packet_words,
    input  logic                  fifo_wr_en,
    input  logic                  fifo_wr_sync,
    input  logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr_overflow,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    output logic                  m_axis_user,
    output logic [31:0]           drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                  last;
        logic                  user;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        STREAM,
        DROP
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;        // index of the next word in the packet
    logic          en_q;
    logic          stg_vld_q, stg_vld_d;
    word_t         stg_q, stg_d;
    word_t         mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          ovf_q;
    logic [31:0]   drop_q;

    logic          full, empty, space, pop;
    logic          en_fall, in_ok;
    logic          start, cont, take, drop, mark_last, commit, new_last;
    logic [15:0]   idx;
    word_t         wr_word, rd_word;

    // The extra MSB on each pointer tells a full FIFO apart from an empty one.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A sync word can be staged if the staging slot is free, or if the slot
    // drains into the FIFO this cycle. Full is judged before any pop, so a
    // same-cycle pop never makes room.
    assign space   = !stg_vld_q || !full;
    assign en_fall = en_q && !enable;
    assign in_ok   = enable && fifo_wr_en;
    assign pop     = !empty && m_axis_ready;

    // ------------------------------------------------------------------
    // Framing FSM and staging register: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stg_vld_d = stg_vld_q;
        stg_d     = stg_q;
        start     = 1'b0;
        cont      = 1'b0;
        take      = 1'b0;
        drop      = 1'b0;
        mark_last = 1'b0;
        new_last  = 1'b0;
        idx       = '0;

        if (en_fall) begin
            // Close the open packet; the staged word drains as last next cycle.
            state_d   = WAIT_SYNC;
            cnt_d     = '0;
            mark_last = 1'b1;
        end else if (in_ok) begin
            unique case (state_q)
                WAIT_SYNC: start = fifo_wr_sync;
                STREAM: begin
                    start     = fifo_wr_sync;
                    cont      = !fifo_wr_sync;
                    mark_last = fifo_wr_sync;     // sync mid-packet closes it
                end
                DROP: begin
                    start = fifo_wr_sync && space;
                    drop  = !start;
                end
                default: ;
            endcase

            if (start || cont) begin
                if (stg_vld_q && full) begin
                    // Overflow: drop the new word and close the packet early.
                    drop      = 1'b1;
                    mark_last = 1'b1;
                    state_d   = DROP;
                    cnt_d     = '0;
                end else begin
                    take     = 1'b1;
                    idx      = start ? 16'd0 : cnt_q;
                    new_last = (packet_words != 16'd0) &&
                               (idx == packet_words - 16'd1);
                    state_d  = new_last ? WAIT_SYNC : STREAM;
                    cnt_d    = new_last ? 16'd0 : idx + 16'd1;
                end
            end
        end

        // A staged word moves on when the next accepted word pushes it out.
        // A staged last word moves on without waiting.
        commit       = stg_vld_q && !full && (take || stg_q.last);
        wr_word      = stg_q;
        wr_word.last = stg_q.last | mark_last;

        if (take) begin
            stg_vld_d  = 1'b1;
            stg_d.last = new_last;
            stg_d.user = start;
            stg_d.data = fifo_wr_data;
        end else if (commit) begin
            stg_vld_d = 1'b0;
        end else if (mark_last && stg_vld_q) begin
            stg_d.last = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= WAIT_SYNC;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            stg_vld_q <= 1'b0;
            stg_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= enable;
            stg_vld_q <= stg_vld_d;
            stg_q     <= stg_d;
            ovf_q     <= drop;
            if (commit) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop && (drop_q != 32'hFFFF_FFFF)) drop_q <= drop_q + 32'd1;
        end
    end

    // FIFO storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (commit) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end

    // ------------------------------------------------------------------
    // First-word-fall-through output. The outputs are gated to zero while
    // empty, so they read 0 out of reset and never show stale storage.
    // ------------------------------------------------------------------
    assign rd_word          = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis_valid     = !empty;
    assign m_axis_data      = empty ? '0   : rd_word.data;
    assign m_axis_last      = empty ? 1'b0 : rd_word.last;
    assign m_axis_user      = empty ? 1'b0 : rd_word.user;
    assign fifo_wr_overflow = ovf_q;
    assign drop_count       = drop_q;

endmodule

// File: tb/tb_packed_fifo_axis_framer.sv
// ----------------------------------------------------------------------------
// tb_packed_fifo_axis_framer
//
// Directed scenarios plus a randomized run. Each is checked every cycle
// against a queue-based reference model of the framing rules, plus explicit
// checks of the output packet contents.
// ----------------------------------------------------------------------------
module tb_packed_fifo_axis_framer;

    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int M_WAIT = 0, M_STREAM = 1, M_DROP = 2;

    typedef struct packed {
        logic          last;
        logic          user;
        logic [DW-1:0] data;
    } w_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          enable = 1'b0;
    logic [15:0]   packet_words = 16'd0;
    logic          fifo_wr_en = 1'b0;
    logic          fifo_wr_sync = 1'b0;
    logic [DW-1:0] fifo_wr_data = '0;
    logic          m_axis_ready = 1'b0;
    logic          fifo_wr_overflow, m_axis_valid, m_axis_last, m_axis_user;
    logic [DW-1:0] m_axis_data;
    logic [31:0]   drop_count;

    int checks = 0;
    int failures = 0;

    // reference model
    w_t          mq[$];
    w_t          sw;
    bit          sv;
    int          mode;
    int          mcnt;
    bit          men_prev;
    bit          movf;
    logic [31:0] mdrop;
    w_t          seen[$];       // words actually popped from the DUT

    packed_fifo_axis_framer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .packet_words(packet_words),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_sync(fifo_wr_sync), .fifo_wr_data(fifo_wr_data),
        .fifo_wr_overflow(fifo_wr_overflow), .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data),
        .m_axis_last(m_axis_last), .m_axis_user(m_axis_user), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        seen.delete();
        sv = 1'b0;
        sw = '0;
        mode = M_WAIT;
        mcnt = 0;
        men_prev = 1'b0;
        movf = 1'b0;
        mdrop = '0;
    endtask

    // One clock of the framing rules, applied to the inputs seen at the edge.
    task automatic model_step(input bit en, input bit wen, input bit sync,
                              input logic [DW-1:0] d, input bit rdy, input int pw);
        int occ, idx;
        bit full, popit, was_last, take, dropped, start, cont;
        w_t nw;
        occ = mq.size();
        full = (occ == DEPTH);
        popit = (occ > 0) && rdy;
        was_last = sv && sw.last;
        take = 1'b0;
        dropped = 1'b0;
        if (men_prev && !en) begin
            if (sv) sw.last = 1'b1;
            mode = M_WAIT;
            mcnt = 0;
        end else if (en && wen) begin
            start = sync && !(mode == M_DROP && sv && full);
            cont  = !sync && (mode == M_STREAM);
            if (start || cont) begin
                if (sv && full) begin
                    dropped = 1'b1;
                    sw.last = 1'b1;
                    mode = M_DROP;
                    mcnt = 0;
                end else begin
                    idx = start ? 0 : mcnt;
                    nw.data = d;
                    nw.user = start;
                    nw.last = (pw != 0) && (idx == pw - 1);
                    if (sv) begin
                        if (start && mode == M_STREAM) sw.last = 1'b1;
                        mq.push_back(sw);
                    end
                    sw = nw;
                    sv = 1'b1;
                    take = 1'b1;
                    if (nw.last) begin mode = M_WAIT; mcnt = 0; end
                    else begin mode = M_STREAM; mcnt = idx + 1; end
                end
            end else if (mode == M_DROP) begin
                dropped = 1'b1;
            end
        end
        if (!take && was_last && !full) begin
            mq.push_back(sw);
            sv = 1'b0;
        end
        if (popit) void'(mq.pop_front());
        movf = dropped;
        if (dropped && mdrop != 32'hFFFF_FFFF) mdrop = mdrop + 32'd1;
        men_prev = en;
    endtask

    task automatic check_outputs();
        chk("valid", m_axis_valid, mq.size() != 0);
        if (mq.size() != 0 && m_axis_valid === 1'b1) begin
            chk("data", m_axis_data, mq[0].data);
            chk("last", m_axis_last, mq[0].last);
            chk("user", m_axis_user, mq[0].user);
        end
        chk("overflow", fifo_wr_overflow, movf);
        chk("drop_count", drop_count, mdrop);
    endtask

    // Called at a negedge: drive, clock, model, check at the next negedge.
    task automatic step(input bit en, input bit wen, input bit sync,
                        input logic [DW-1:0] d, input bit rdy);
        w_t o;
        enable = en;
        fifo_wr_en = wen;
        fifo_wr_sync = sync;
        fifo_wr_data = d;
        m_axis_ready = rdy;
        #1;
        if (m_axis_valid === 1'b1 && rdy) begin
            o.data = m_axis_data;
            o.last = m_axis_last;
            o.user = m_axis_user;
            seen.push_back(o);
        end
        @(posedge clk);
        model_step(en, wen, sync, d, rdy, int'(packet_words));
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_async_valid", m_axis_valid, 1'b0);
        enable = 1'b0;
        fifo_wr_en = 1'b0;
        fifo_wr_sync = 1'b0;
        m_axis_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_valid", m_axis_valid, 1'b0);
        chk("rst_data", m_axis_data, '0);
        chk("rst_overflow", fifo_wr_overflow, 1'b0);
        chk("rst_drop", drop_count, 32'd0);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int pwt[4];
        pwt = '{0, 1, 3, 5};
        #3;
        do_reset();

        // 1: four-word packets
        packet_words = 16'd4;
        step(1, 1, 1, 'h100, 1);
        for (int i = 1; i < 4; i++) step(1, 1, 0, DW'('h100 + i), 1);
        step(1, 1, 1, 'h104, 1);
        step(1, 1, 1, 'h105, 1);
        idle(4, 1);
        chk("t1_count", seen.size(), 5);
        if (seen.size() >= 5) begin
            chk("t1_first", {seen[0].user, seen[0].last, seen[0].data}, {2'b10, DW'('h100)});
            chk("t1_last", {seen[3].user, seen[3].last, seen[3].data}, {2'b01, DW'('h103)});
            chk("t1_next", {seen[4].user, seen[4].data}, {1'b1, DW'('h104)});
        end

        // 2: non-sync words before the first sync are discarded silently
        do_reset();
        packet_words = 16'd1;
        step(1, 1, 0, 'hA, 1);
        step(1, 1, 0, 'hB, 1);
        step(1, 1, 1, 'hC, 1);
        idle(4, 1);
        chk("t2_count", seen.size(), 1);
        if (seen.size() >= 1)
            chk("t2_word", {seen[0].user, seen[0].last, seen[0].data}, {2'b11, DW'('hC)});
        chk("t2_drop", drop_count, 32'd0);

        // 3: overflow with a stalled sink
        do_reset();
        packet_words = 16'd0;
        step(1, 1, 1, 'h200, 0);
        for (int i = 1; i <= 16; i++) step(1, 1, 0, DW'('h200 + i), 0);
        step(1, 1, 0, 'h2FF, 0);
        chk("t3_ovf_pulse", fifo_wr_overflow, 1'b1);
        for (int i = 0; i < 5; i++) step(1, 1, 0, rnd_word(), 0);
        chk("t3_drop", drop_count, 32'd6);
        idle(20, 1);
        chk("t3_count", seen.size(), 17);
        if (seen.size() >= 17)
            chk("t3_closed", {seen[16].last, seen[16].data}, {1'b1, DW'('h210)});
        step(1, 1, 1, 'h300, 1);
        step(1, 1, 1, 'h301, 1);
        idle(3, 1);
        if (seen.size() >= 18)
            chk("t3_restart", {seen[17].user, seen[17].last, seen[17].data}, {2'b11, DW'('h300)});

        // 4: sync word arriving mid-packet
        do_reset();
        packet_words = 16'd4;
        step(1, 1, 1, 'h400, 1);
        step(1, 1, 0, 'h401, 1);
        step(1, 1, 1, 'h402, 1);
        step(1, 1, 0, 'h403, 1);
        idle(4, 1);
        chk("t4_count", seen.size(), 3);
        if (seen.size() >= 3) begin
            chk("t4_cut", {seen[1].last, seen[1].data}, {1'b1, DW'('h401)});
            chk("t4_new", {seen[2].user, seen[2].data}, {1'b1, DW'('h402)});
        end

        // 5: enable dropped mid-packet
        do_reset();
        packet_words = 16'd0;
        step(1, 1, 1, 'h500, 1);
        step(1, 1, 0, 'h501, 1);
        step(1, 1, 0, 'h502, 1);
        for (int i = 0; i < 3; i++) step(0, 1, i == 1, DW'('h5A0 + i), 1);
        step(1, 1, 0, 'h5B0, 1);
        step(1, 1, 0, 'h5B1, 1);
        step(1, 1, 1, 'h509, 1);
        step(1, 1, 1, 'h50A, 1);
        idle(4, 1);
        chk("t5_count", seen.size(), 4);
        if (seen.size() >= 4) begin
            chk("t5_closed", {seen[2].last, seen[2].data}, {1'b1, DW'('h502)});
            chk("t5_resume", {seen[3].user, seen[3].data}, {1'b1, DW'('h509)});
        end

        // 6: asynchronous reset while output is valid
        step(1, 1, 1, 'h600, 0);
        for (int i = 1; i < 4; i++) step(1, 1, 0, DW'('h600 + i), 0);
        chk("t6_valid_before", m_axis_valid, 1'b1);
        #2;
        do_reset();
        idle(2, 1);

        // randomized traffic
        for (int blk = 0; blk < 8; blk++) begin
            do_reset();
            packet_words = 16'(pwt[blk % 4]);
            for (int c = 0; c < 400; c++)
                step(($urandom_range(0, 99) < 95), ($urandom_range(0, 99) < 80),
                     ($urandom_range(0, 99) < 15), rnd_word(),
                     ($urandom_range(0, 99) < (blk < 4 ? 60 : 25)));
            idle(24, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
